rob_multi_cdb: RTL and testbench

- Parametrised successor to the current 16-entry reorder buffer.
- Circular in-order commit queue between decoder/issue and register file / LSB / predictor.
- Generalised: configurable depth, N result-broadcast (CDB) channels with same-cycle operand forwarding, occupancy counter, LSB store-commit backpressure, predictor update on every committed branch.
- On a branch mispredict it self-flushes and redirects fetch.

---
 rtl/rob_pkg.sv | 34 +++
 rtl/rob_cdb_fwd.sv | 27 ++
 rtl/rob_multi_cdb.sv | 195 +++++++++++++++++++
 tb/tb_rob_multi_cdb.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared constants, entry layout and opcode classification for the reorder buffer.
package rob_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OPC_BRANCH = 3'b100;
    localparam logic [2:0] OPC_LOAD   = 3'b101;
    localparam logic [2:0] OPC_STORE  = 3'b111;

    typedef enum logic [1:0] {
        CLS_REG,
        CLS_BRANCH,
        CLS_STORE
    } op_class_e;

    typedef struct packed {
        logic [5:0]      op;
        logic [4:0]      rd;
        logic [XLEN-1:0] val;
        logic            pred_jump;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alt_pc;
    } rob_entry_t;

    function automatic op_class_e op_class(input logic [5:0] op);
        case (op[5:3])
            OPC_BRANCH: return CLS_BRANCH;
            OPC_STORE:  return CLS_STORE;
            OPC_LOAD:   return CLS_REG;
            default:    return CLS_REG;
        endcase
    endfunction

endpackage

// File: rtl/rob_cdb_fwd.sv
// Tag match against all CDB channels; the highest-index matching channel supplies the value.
module rob_cdb_fwd
    import rob_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int NUM_CDB = 2
) (
    input  logic [TAG_W-1:0]         tag,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_val,
    output logic                     hit,
    output logic [XLEN-1:0]          val
);

    always_comb begin
        hit = 1'b0;
        val = '0;
        for (int unsigned i = 0; i < NUM_CDB; i++) begin
            if (cdb_valid[i] && (cdb_tag[i*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
                val = cdb_val[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/rob_multi_cdb.sv
// Circular reorder buffer with multi-channel CDB write-back, operand forwarding,
// store backpressure, predictor update and self-flush on branch mispredict.
module rob_multi_cdb
    import rob_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int NUM_CDB = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     issue_valid,
    input  logic [5:0]               issue_op,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_done,
    input  logic [31:0]              issue_val,
    input  logic                     issue_pred_jump,
    input  logic [31:0]              issue_pc,
    input  logic [31:0]              issue_alt_pc,
    output logic                     full,
    output logic [TAG_W-1:0]         tail_tag,
    output logic [TAG_W-1:0]         head_tag,
    output logic [TAG_W:0]           count,
    input  logic [TAG_W-1:0]         q_tag_a,
    input  logic [TAG_W-1:0]         q_tag_b,
    output logic                     q_ok_a,
    output logic                     q_ok_b,
    output logic [31:0]              q_val_a,
    output logic [31:0]              q_val_b,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*32-1:0]    cdb_val,
    input  logic                     lsb_ready,
    output logic                     reg_commit,
    output logic [4:0]               reg_commit_rd,
    output logic [TAG_W-1:0]         reg_commit_tag,
    output logic [31:0]              reg_commit_val,
    output logic                     store_commit,
    output logic [TAG_W-1:0]         store_tag,
    output logic                     pred_upd,
    output logic [31:0]              pred_pc,
    output logic                     pred_taken,
    output logic                     flush,
    output logic [31:0]              redirect_pc
);

    localparam int DEPTH = 2 ** TAG_W;

    rob_entry_t       ent [DEPTH];
    logic [DEPTH-1:0] ok;

    rob_entry_t  head_ent;
    op_class_e   head_cls;
    logic        can_commit;
    logic        mispredict;
    logic        issue_acc;

    logic [DEPTH-1:0] wb_hit;
    logic [XLEN-1:0]  wb_val [DEPTH];

    logic             fa_hit, fb_hit;
    logic [XLEN-1:0]  fa_val, fb_val;

    assign full = (count == (TAG_W+1)'(DEPTH));

    always_comb begin
        head_ent   = ent[head_tag];
        head_cls   = op_class(head_ent.op);
        issue_acc  = issue_valid && !full;
        can_commit = (count != '0) && ok[head_tag] &&
                     ((head_cls != CLS_STORE) || lsb_ready);
        mispredict = can_commit && (head_cls == CLS_BRANCH) &&
                     (head_ent.val[0] != head_ent.pred_jump);
    end

    // One matcher per entry turns the CDB buses into per-entry write enables.
    for (genvar e = 0; e < DEPTH; e++) begin : g_wb
        rob_cdb_fwd #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_wb (
            .tag       (TAG_W'(e)),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_val   (cdb_val),
            .hit       (wb_hit[e]),
            .val       (wb_val[e])
        );
    end

    rob_cdb_fwd #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_qa (
        .tag       (q_tag_a),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_val   (cdb_val),
        .hit       (fa_hit),
        .val       (fa_val)
    );

    rob_cdb_fwd #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_qb (
        .tag       (q_tag_b),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_val   (cdb_val),
        .hit       (fb_hit),
        .val       (fb_val)
    );

    always_comb begin
        q_ok_a  = fa_hit || ok[q_tag_a];
        q_ok_b  = fb_hit || ok[q_tag_b];
        q_val_a = fa_hit ? fa_val : (ok[q_tag_a] ? ent[q_tag_a].val : '0);
        q_val_b = fb_hit ? fb_val : (ok[q_tag_b] ? ent[q_tag_b].val : '0);
    end

    // Entry payload; issue is applied after CDB so a fresh allocation wins on its own tag.
    always_ff @(posedge clk) begin
        if (!rst && rdy && !mispredict) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (wb_hit[e]) begin
                    ent[e].val <= wb_val[e];
                end
            end
            if (issue_acc) begin
                ent[tail_tag] <= '{op: issue_op, rd: issue_rd, val: issue_val,
                                   pred_jump: issue_pred_jump, pc: issue_pc,
                                   alt_pc: issue_alt_pc};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_tag       <= '0;
            tail_tag       <= '0;
            count          <= '0;
            ok             <= '0;
            reg_commit     <= 1'b0;
            reg_commit_rd  <= '0;
            reg_commit_tag <= '0;
            reg_commit_val <= '0;
            store_commit   <= 1'b0;
            store_tag      <= '0;
            pred_upd       <= 1'b0;
            pred_pc        <= '0;
            pred_taken     <= 1'b0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
        end else if (rdy) begin
            reg_commit   <= 1'b0;
            store_commit <= 1'b0;
            pred_upd     <= 1'b0;
            flush        <= 1'b0;
            if (can_commit) begin
                head_tag <= head_tag + 1'b1;
                case (head_cls)
                    CLS_STORE: begin
                        store_commit <= 1'b1;
                        store_tag    <= head_tag;
                    end
                    CLS_BRANCH: begin
                        pred_upd   <= 1'b1;
                        pred_pc    <= head_ent.pc;
                        pred_taken <= head_ent.val[0];
                        if (mispredict) begin
                            flush       <= 1'b1;
                            redirect_pc <= head_ent.alt_pc;
                        end
                    end
                    default: begin
                        reg_commit     <= 1'b1;
                        reg_commit_rd  <= head_ent.rd;
                        reg_commit_tag <= head_tag;
                        reg_commit_val <= head_ent.val;
                    end
                endcase
            end
            if (mispredict) begin
                head_tag <= '0;
                tail_tag <= '0;
                count    <= '0;
                ok       <= '0;
            end else begin
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    if (wb_hit[e]) begin
                        ok[e] <= 1'b1;
                    end
                end
                if (issue_acc) begin
                    ok[tail_tag] <= issue_done;
                    tail_tag     <= tail_tag + 1'b1;
                end
                count <= count + (TAG_W+1)'(issue_acc) - (TAG_W+1)'(can_commit);
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_cdb.sv
// Directed self-checking bench for rob_multi_cdb (TAG_W=4, NUM_CDB=2).
module tb_rob_multi_cdb;

    localparam int TAG_W   = 4;
    localparam int NUM_CDB = 2;

    logic                     clk = 1'b0;
    logic                     rst, rdy;
    logic                     issue_valid, issue_done, issue_pred_jump;
    logic [5:0]               issue_op;
    logic [4:0]               issue_rd;
    logic [31:0]              issue_val, issue_pc, issue_alt_pc;
    logic                     full;
    logic [TAG_W-1:0]         tail_tag, head_tag;
    logic [TAG_W:0]           count;
    logic [TAG_W-1:0]         q_tag_a, q_tag_b;
    logic                     q_ok_a, q_ok_b;
    logic [31:0]              q_val_a, q_val_b;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*32-1:0]    cdb_val;
    logic                     lsb_ready;
    logic                     reg_commit, store_commit, pred_upd, pred_taken, flush;
    logic [4:0]               reg_commit_rd;
    logic [TAG_W-1:0]         reg_commit_tag, store_tag;
    logic [31:0]              reg_commit_val, pred_pc, redirect_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rob_multi_cdb #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_rd(issue_rd),
        .issue_done(issue_done), .issue_val(issue_val),
        .issue_pred_jump(issue_pred_jump), .issue_pc(issue_pc),
        .issue_alt_pc(issue_alt_pc),
        .full(full), .tail_tag(tail_tag), .head_tag(head_tag), .count(count),
        .q_tag_a(q_tag_a), .q_tag_b(q_tag_b), .q_ok_a(q_ok_a), .q_ok_b(q_ok_b),
        .q_val_a(q_val_a), .q_val_b(q_val_b),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .lsb_ready(lsb_ready),
        .reg_commit(reg_commit), .reg_commit_rd(reg_commit_rd),
        .reg_commit_tag(reg_commit_tag), .reg_commit_val(reg_commit_val),
        .store_commit(store_commit), .store_tag(store_tag),
        .pred_upd(pred_upd), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .flush(flush), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [5:0] op, input logic [4:0] rd, input logic done,
                             input logic [31:0] val, input logic pj,
                             input logic [31:0] pc, input logic [31:0] alt);
        issue_valid     = 1'b1;
        issue_op        = op;
        issue_rd        = rd;
        issue_done      = done;
        issue_val       = val;
        issue_pred_jump = pj;
        issue_pc        = pc;
        issue_alt_pc    = alt;
    endtask

    task automatic set_cdb(input int ch, input logic [TAG_W-1:0] tag, input logic [31:0] val);
        cdb_valid[ch]              = 1'b1;
        cdb_tag[ch*TAG_W +: TAG_W] = tag;
        cdb_val[ch*32 +: 32]       = val;
    endtask

    task automatic clr_cdb();
        cdb_valid = '0;
        cdb_tag   = '0;
        cdb_val   = '0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; lsb_ready = 1'b1;
        issue_valid = 1'b0; issue_op = '0; issue_rd = '0; issue_done = 1'b0;
        issue_val = '0; issue_pred_jump = 1'b0; issue_pc = '0; issue_alt_pc = '0;
        q_tag_a = '0; q_tag_b = '0;
        clr_cdb();
        step(); step();
        rst = 1'b0;

        chk("reset_count", 64'(count), 64'd0);
        chk("reset_head", 64'(head_tag), 64'd0);
        chk("reset_tail", 64'(tail_tag), 64'd0);
        chk("reset_full", 64'(full), 64'd0);
        chk("reset_reg_commit", 64'(reg_commit), 64'd0);
        chk("reset_flush", 64'(flush), 64'd0);
        chk("reset_q_ok", 64'(q_ok_a), 64'd0);

        // Fill: entry 0 not done so nothing commits until it resolves.
        for (int i = 0; i < 16; i++) begin
            set_issue(6'b000000, 5'(i + 1), (i != 0), 32'h1000 + 32'(i), 1'b0, '0, '0);
            step();
        end
        chk("fill_count", 64'(count), 64'd16);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_tail_wrap", 64'(tail_tag), 64'd0);
        step();
        issue_valid = 1'b0;
        chk("full_issue_ignored", 64'(count), 64'd16);
        chk("full_no_commit", 64'(reg_commit), 64'd0);

        set_cdb(0, 4'd0, 32'hAAAA);
        q_tag_a = 4'd0;
        #1;
        chk("fwd_q_ok", 64'(q_ok_a), 64'd1);
        chk("fwd_q_val", 64'(q_val_a), 64'hAAAA);
        step();
        clr_cdb();
        chk("wb_no_commit_yet", 64'(reg_commit), 64'd0);
        for (int k = 0; k < 16; k++) begin
            step();
            chk("drain_commit", 64'(reg_commit), 64'd1);
            chk("drain_tag", 64'(reg_commit_tag), 64'(k));
            chk("drain_rd", 64'(reg_commit_rd), 64'(k + 1));
            chk("drain_val", 64'(reg_commit_val), (k == 0) ? 64'hAAAA : 64'h1000 + 64'(k));
        end
        chk("drain_count", 64'(count), 64'd0);
        step();
        chk("drain_idle", 64'(reg_commit), 64'd0);

        // Out-of-order completion, in-order commit.
        for (int i = 0; i < 3; i++) begin
            set_issue(6'b000001, 5'(i + 5), 1'b0, '0, 1'b0, '0, '0);
            step();
        end
        issue_valid = 1'b0;
        set_cdb(1, 4'd1, 32'h55);
        q_tag_a = 4'd1; q_tag_b = 4'd0;
        #1;
        chk("q1_ok", 64'(q_ok_a), 64'd1);
        chk("q1_val", 64'(q_val_a), 64'h55);
        chk("q0_not_ok", 64'(q_ok_b), 64'd0);
        chk("q0_val_zero", 64'(q_val_b), 64'd0);
        step();
        clr_cdb();
        chk("ooo_no_commit_a", 64'(reg_commit), 64'd0);
        q_tag_a = 4'd1;
        #1;
        chk("q1_stored", 64'(q_val_a), 64'h55);
        set_cdb(0, 4'd2, 32'h22);
        step();
        clr_cdb();
        chk("ooo_no_commit_b", 64'(reg_commit), 64'd0);
        set_cdb(0, 4'd0, 32'h11);
        step();
        clr_cdb();
        chk("ooo_no_commit_c", 64'(reg_commit), 64'd0);
        step();
        chk("ooo_c0_tag", 64'(reg_commit_tag), 64'd0);
        chk("ooo_c0_val", 64'(reg_commit_val), 64'h11);
        chk("ooo_c0_rd", 64'(reg_commit_rd), 64'd5);
        step();
        chk("ooo_c1_tag", 64'(reg_commit_tag), 64'd1);
        chk("ooo_c1_val", 64'(reg_commit_val), 64'h55);
        step();
        chk("ooo_c2_tag", 64'(reg_commit_tag), 64'd2);
        chk("ooo_c2_val", 64'(reg_commit_val), 64'h22);
        step();
        chk("ooo_idle", 64'(reg_commit), 64'd0);
        chk("ooo_count", 64'(count), 64'd0);

        set_cdb(0, 4'd3, 32'h1);
        set_cdb(1, 4'd3, 32'h2);
        q_tag_a = 4'd3;
        #1;
        chk("collide_high_wins", 64'(q_val_a), 64'h2);
        clr_cdb();

        // Mispredicted branch at tag 3 with younger entries 4, 5.
        set_issue(6'b100000, 5'd0, 1'b0, '0, 1'b0, 32'h40, 32'h100);
        step();
        set_issue(6'b000000, 5'd1, 1'b1, 32'h4, 1'b0, '0, '0);
        step();
        set_issue(6'b000000, 5'd2, 1'b1, 32'h5, 1'b0, '0, '0);
        step();
        issue_valid = 1'b0;
        set_cdb(0, 4'd3, 32'h1);
        step();
        clr_cdb();
        chk("mp_pre_count", 64'(count), 64'd3);
        set_issue(6'b000000, 5'd3, 1'b1, 32'h6, 1'b0, '0, '0);
        set_cdb(1, 4'd4, 32'h77);
        step();
        issue_valid = 1'b0;
        clr_cdb();
        chk("mp_pred_upd", 64'(pred_upd), 64'd1);
        chk("mp_pred_pc", 64'(pred_pc), 64'h40);
        chk("mp_pred_taken", 64'(pred_taken), 64'd1);
        chk("mp_flush", 64'(flush), 64'd1);
        chk("mp_redirect", 64'(redirect_pc), 64'h100);
        chk("mp_count", 64'(count), 64'd0);
        chk("mp_head", 64'(head_tag), 64'd0);
        chk("mp_tail", 64'(tail_tag), 64'd0);
        chk("mp_no_reg_commit", 64'(reg_commit), 64'd0);
        step();
        chk("mp_flush_pulse", 64'(flush), 64'd0);
        chk("mp_upd_pulse", 64'(pred_upd), 64'd0);
        chk("mp_still_empty", 64'(count), 64'd0);

        // Correctly predicted branch keeps the younger entry.
        set_issue(6'b100000, 5'd0, 1'b1, 32'h1, 1'b1, 32'h80, 32'h200);
        step();
        set_issue(6'b000000, 5'd9, 1'b1, 32'h77, 1'b0, '0, '0);
        step();
        issue_valid = 1'b0;
        chk("ok_pred_upd", 64'(pred_upd), 64'd1);
        chk("ok_pred_pc", 64'(pred_pc), 64'h80);
        chk("ok_pred_taken", 64'(pred_taken), 64'd1);
        chk("ok_no_flush", 64'(flush), 64'd0);
        chk("ok_retained", 64'(count), 64'd1);
        step();
        chk("ok_young_commit", 64'(reg_commit), 64'd1);
        chk("ok_young_tag", 64'(reg_commit_tag), 64'd1);
        chk("ok_young_val", 64'(reg_commit_val), 64'h77);
        chk("ok_count", 64'(count), 64'd0);

        // Store held back by the LSB.
        lsb_ready = 1'b0;
        set_issue(6'b111000, 5'd0, 1'b1, 32'h0, 1'b0, '0, '0);
        step();
        issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_stall", 64'(store_commit), 64'd0);
            chk("st_stall_count", 64'(count), 64'd1);
        end
        lsb_ready = 1'b1;
        step();
        chk("st_commit", 64'(store_commit), 64'd1);
        chk("st_tag", 64'(store_tag), 64'd2);
        chk("st_no_reg", 64'(reg_commit), 64'd0);
        chk("st_count", 64'(count), 64'd0);
        step();
        chk("st_pulse", 64'(store_commit), 64'd0);

        // Freeze with pending CDB and issue, then resume.
        set_issue(6'b000000, 5'd3, 1'b0, '0, 1'b0, '0, '0);
        step();
        rdy = 1'b0;
        set_issue(6'b000000, 5'd4, 1'b1, 32'h44, 1'b0, '0, '0);
        set_cdb(0, 4'd3, 32'h99);
        step(); step();
        chk("frz_count", 64'(count), 64'd1);
        chk("frz_head", 64'(head_tag), 64'd3);
        chk("frz_tail", 64'(tail_tag), 64'd4);
        chk("frz_no_commit", 64'(reg_commit), 64'd0);
        rdy = 1'b1;
        step();
        issue_valid = 1'b0;
        clr_cdb();
        chk("res_count", 64'(count), 64'd2);
        chk("res_tail", 64'(tail_tag), 64'd5);
        step();
        chk("res_c0_tag", 64'(reg_commit_tag), 64'd3);
        chk("res_c0_val", 64'(reg_commit_val), 64'h99);
        chk("res_c0_rd", 64'(reg_commit_rd), 64'd3);
        step();
        chk("res_c1_tag", 64'(reg_commit_tag), 64'd4);
        chk("res_c1_val", 64'(reg_commit_val), 64'h44);
        chk("res_count_end", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
